// File: rtl/ram_arb_pkg.sv
// Shared types and the rotate-priority pick function for the RAM arbiter.
// Optional lock feature is selected by RAM_ARB_LOCK_EN in ram_sx_arb.
package ram_arb_pkg;

  localparam int unsigned CPortCntMax = 8;
  localparam int unsigned CIdxLen     = $clog2(CPortCntMax);
  localparam int unsigned CCntLen     = CIdxLen + 1;

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic               found;
    logic [CIdxLen-1:0] idx;
  } rr_pick_t;

  // First requesting port scanning prio, prio+1, ... wrapping at cnt ports.
  function automatic rr_pick_t rr_pick(input logic [CPortCntMax-1:0] req,
                                       input logic [CIdxLen-1:0]     prio,
                                       input logic [CCntLen-1:0]     cnt);
    rr_pick_t           res;
    logic [CCntLen-1:0] pos;
    res = '0;
    for (int unsigned ofs = 0; ofs < CPortCntMax; ofs++) begin
      pos = CCntLen'(prio) + CCntLen'(ofs);
      if (pos >= cnt) pos = pos - cnt;
      if ((CCntLen'(ofs) < cnt) && !res.found && req[pos[CIdxLen-1:0]]) begin
        res.found = 1'b1;
        res.idx   = pos[CIdxLen-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_arb_rr_pick.sv
// Combinational rotate-priority picker: request vector + priority pointer
// to one-hot grant, grant index and a grant-present flag.
module ram_arb_rr_pick
  import ram_arb_pkg::*;
#(
  parameter int unsigned CPortCnt = 2
) (
  input  logic [CPortCnt-1:0] req,
  input  logic [CIdxLen-1:0]  prio,
  output logic [CPortCnt-1:0] gnt,
  output logic [CIdxLen-1:0]  idx,
  output logic                vld
);

  rr_pick_t pick;

  always_comb begin
    pick = rr_pick(CPortCntMax'(req), prio, CCntLen'(CPortCnt));
    vld  = pick.found;
    idx  = pick.idx;
    gnt  = pick.found ? (CPortCnt'(1) << pick.idx) : '0;
  end

endmodule

// File: rtl/ram_sx_arb.sv
// Round-robin arbiter sharing one single-port synchronous RAM between CPortCnt ports.
// Define RAM_ARB_LOCK_EN to add ALock/AErrLock and the bounded ownership lock.
module ram_sx_arb
  import ram_arb_pkg::*;
#(
  parameter int unsigned CPortCnt = 2,
  parameter int unsigned CAddrLen = 13,
  parameter int unsigned CDataLen = 128,
  parameter int unsigned CLockMax = 16
) (
  input  logic                         AClkH,
  input  logic                         AResetHN,
  input  logic                         AClkHEn,
  input  logic [CPortCnt*CAddrLen-1:0] AReqAddr,
  input  logic [CPortCnt*CDataLen-1:0] AReqMosi,
  input  logic [CPortCnt-1:0]          AReqWr,
  input  logic [CPortCnt-1:0]          AReqRd,
  output logic [CPortCnt-1:0]          AGnt,
  output logic [CPortCnt-1:0]          ARdVld,
  output logic [CDataLen-1:0]          ARdData,
  output logic [CAddrLen-1:0]          AMemAddr,
  output logic [CDataLen-1:0]          AMemMosi,
  input  logic [CDataLen-1:0]          AMemMiso,
  output logic                         AMemWrEn,
  output logic                         AMemRdEn
`ifdef RAM_ARB_LOCK_EN
  ,
  input  logic [CPortCnt-1:0]          ALock,
  output logic                         AErrLock
`endif
);

  if ((CPortCnt < 2) || (CPortCnt > CPortCntMax) || (CLockMax < 2)) begin : g_bad_cfg
    $error("ram_sx_arb: unsupported CPortCnt/CLockMax");
  end

  logic [CPortCnt-1:0] req;
  logic [CPortCnt-1:0] elig;
  logic [CPortCnt-1:0] pick_gnt;
  logic [CIdxLen-1:0]  pick_idx;
  logic [CIdxLen-1:0]  prio_nxt;
  logic                pick_vld;
  logic                gnt_vld;
  logic [CIdxLen-1:0]  FPrio;
  logic [CPortCnt-1:0] FRdTag;

  assign req = AReqWr | AReqRd;

`ifdef RAM_ARB_LOCK_EN
  localparam int unsigned CLockCntLen = $clog2(CLockMax + 1);

  arb_state_e             FState;
  logic [CIdxLen-1:0]     FOwn;
  logic [CLockCntLen-1:0] FLockCnt;
  logic [CPortCnt-1:0]    own_oh;
  logic                   own_hold;
  logic                   lock_force;
  logic                   pick_lock;
  logic [CIdxLen-1:0]     own_nxt;

  // While the owner keeps ALock high only the owner may be granted.
  always_comb begin
    own_oh     = CPortCnt'(1) << FOwn;
    own_hold   = (FState == LOCKED) && (|(ALock & own_oh));
    lock_force = own_hold && (FLockCnt == CLockCntLen'(CLockMax - 1));
    elig       = own_hold ? (req & own_oh) : req;
    pick_lock  = |(ALock & pick_gnt);
    own_nxt    = (FOwn == CIdxLen'(CPortCnt - 1)) ? '0 : FOwn + CIdxLen'(1);
  end

  assign AErrLock = lock_force & AClkHEn & AResetHN;

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      FState   <= FREE;
      FOwn     <= '0;
      FLockCnt <= '0;
    end else if (AClkHEn) begin
      case (FState)
        FREE: begin
          if (gnt_vld && pick_lock) begin
            FState   <= LOCKED;
            FOwn     <= pick_idx;
            FLockCnt <= '0;
          end
        end
        LOCKED: begin
          if (lock_force) begin
            FState   <= FREE;
            FLockCnt <= '0;
          end else if (own_hold) begin
            FLockCnt <= FLockCnt + CLockCntLen'(1);
          end else if (gnt_vld && pick_lock) begin
            FOwn     <= pick_idx;
            FLockCnt <= '0;
          end else begin
            FState <= FREE;
          end
        end
        default: FState <= FREE;
      endcase
    end
  end
`else
  assign elig = req;
`endif

  ram_arb_rr_pick #(
    .CPortCnt (CPortCnt)
  ) u_pick (
    .req  (elig),
    .prio (FPrio),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  assign gnt_vld  = pick_vld & AClkHEn & AResetHN;
  assign AGnt     = gnt_vld ? pick_gnt : '0;
  assign prio_nxt = (pick_idx == CIdxLen'(CPortCnt - 1)) ? '0 : pick_idx + CIdxLen'(1);
  assign ARdVld   = FRdTag;
  assign ARdData  = AMemMiso;

  // Forward the granted port's request to the RAM; idle drives zeros.
  always_comb begin
    AMemAddr = '0;
    AMemMosi = '0;
    AMemWrEn = 1'b0;
    AMemRdEn = 1'b0;
    for (int unsigned i = 0; i < CPortCnt; i++) begin
      if (AGnt[i]) begin
        AMemAddr = AReqAddr[i*CAddrLen +: CAddrLen];
        AMemMosi = AReqMosi[i*CDataLen +: CDataLen];
        AMemWrEn = AReqWr[i];
        AMemRdEn = AReqRd[i];
      end
    end
  end

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      FPrio  <= '0;
      FRdTag <= '0;
    end else if (AClkHEn) begin
      FRdTag <= AGnt & AReqRd;
      if (gnt_vld) FPrio <= prio_nxt;
`ifdef RAM_ARB_LOCK_EN
      if (lock_force) FPrio <= own_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ram_sx_arb.sv
// Scoreboard bench for ram_sx_arb with two ports and a write-first single-port RAM model.
// Lock scenarios run only when RAM_ARB_LOCK_EN is defined.
module tb_ram_sx_arb;

  localparam int unsigned NP = 2;
  localparam int unsigned AL = 13;
  localparam int unsigned DL = 128;

  typedef struct packed {
    logic [NP-1:0] gnt;
    logic          wr;
    logic          rd;
    logic [AL-1:0] addr;
    logic          err;
  } gexp_t;

  typedef struct packed {
    logic [NP-1:0] vld;
    logic [DL-1:0] data;
  } rexp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [NP*AL-1:0] req_addr;
  logic [NP*DL-1:0] req_mosi;
  logic [NP-1:0]    req_wr;
  logic [NP-1:0]    req_rd;
  logic [NP-1:0]    gnt;
  logic [NP-1:0]    rd_vld;
  logic [DL-1:0]    rd_data;
  logic [AL-1:0]    mem_addr;
  logic [DL-1:0]    mem_mosi;
  logic [DL-1:0]    mem_miso;
  logic             mem_wr;
  logic             mem_rd;
`ifdef RAM_ARB_LOCK_EN
  logic [NP-1:0]    alock;
  logic             err_lock;
`endif

  gexp_t gq[$];
  rexp_t rq[$];
  int    checks = 0;
  int    errors = 0;
  logic  last_en = 1'b0;

  localparam logic [DL-1:0] DA5 = {16{8'hA5}};
  localparam logic [DL-1:0] D1  = {4{32'h1111_0001}};
  localparam logic [DL-1:0] D2  = {4{32'h2222_0002}};
  localparam logic [DL-1:0] D7  = {4{32'h7777_0007}};

  ram_sx_arb #(
    .CPortCnt (NP),
    .CAddrLen (AL),
    .CDataLen (DL),
    .CLockMax (16)
  ) dut (
    .AClkH    (clk),
    .AResetHN (rst_n),
    .AClkHEn  (en),
    .AReqAddr (req_addr),
    .AReqMosi (req_mosi),
    .AReqWr   (req_wr),
    .AReqRd   (req_rd),
    .AGnt     (gnt),
    .ARdVld   (rd_vld),
    .ARdData  (rd_data),
    .AMemAddr (mem_addr),
    .AMemMosi (mem_mosi),
    .AMemMiso (mem_miso),
    .AMemWrEn (mem_wr),
    .AMemRdEn (mem_rd)
`ifdef RAM_ARB_LOCK_EN
    ,
    .ALock    (alock),
    .AErrLock (err_lock)
`endif
  );

  always #5 clk = ~clk;

  // Single-port RAM, registered read, write-first.
  logic [DL-1:0] mem [0:(1<<AL)-1];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_mosi;
    if (mem_rd) mem_miso <= mem_wr ? mem_mosi : mem[mem_addr];
  end

  always @(posedge clk) last_en <= en;

  // Monitor: per-cycle grant/RAM-side check, read returns checked when presented.
  always @(negedge clk) begin : monitor
    gexp_t e;
    gexp_t a;
    rexp_t r;
    if (gq.size() > 0) begin
      e = gq.pop_front();
      a.gnt  = gnt;
      a.wr   = mem_wr;
      a.rd   = mem_rd;
      a.addr = mem_addr;
`ifdef RAM_ARB_LOCK_EN
      a.err  = err_lock;
`else
      a.err  = 1'b0;
`endif
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL grant_cycle t=%0t actual gnt=%b wr=%b rd=%b addr=%h err=%b required gnt=%b wr=%b rd=%b addr=%h err=%b",
                 $time, a.gnt, a.wr, a.rd, a.addr, a.err, e.gnt, e.wr, e.rd, e.addr, e.err);
      end
    end
    if ((rd_vld !== '0) && last_en) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL read_return t=%0t unexpected vld=%b data=%h", $time, rd_vld, rd_data);
      end else begin
        r = rq.pop_front();
        if ((rd_vld !== r.vld) || (rd_data !== r.data)) begin
          errors++;
          $display("FAIL read_return t=%0t actual vld=%b data=%h required vld=%b data=%h",
                   $time, rd_vld, rd_data, r.vld, r.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic wr, input logic rd,
                       input logic [AL-1:0] addr, input logic [DL-1:0] data);
    req_wr[p] = wr;
    req_rd[p] = rd;
    req_addr[p*AL +: AL] = addr;
    req_mosi[p*DL +: DL] = data;
  endtask

  task automatic idle_ports();
    req_wr = '0;
    req_rd = '0;
    req_addr = '0;
    req_mosi = '0;
  endtask

  task automatic exp_rd(input int p, input logic [DL-1:0] d);
    rexp_t r;
    r.vld  = NP'(1) << p;
    r.data = d;
    rq.push_back(r);
  endtask

  // Queue this cycle's expected grant/RAM side, then advance to #1 after the edge.
  task automatic step(input logic [NP-1:0] g, input logic wr, input logic rd,
                      input logic [AL-1:0] addr, input logic err);
    gexp_t e;
    e.gnt = g; e.wr = wr; e.rd = rd; e.addr = addr; e.err = err;
    gq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b1;
    idle_ports();
`ifdef RAM_ARB_LOCK_EN
    alock = '0;
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n = 1'b0;
    en = 1'b1;
    idle_ports();
`ifdef RAM_ARB_LOCK_EN
    alock = '0;
`endif
    #2;
    // Outputs held idle during reset even with a request pending.
    drive(0, 1'b0, 1'b1, 13'h0AA, DA5);
    #1;
    chk("reset_gnt", 160'(gnt), 160'(0));
    chk("reset_rdvld", 160'(rd_vld), 160'(0));
    chk("reset_mem", 160'({mem_wr, mem_rd, mem_addr, mem_mosi}), 160'(0));
    do_reset();

    // Test 1: write then read back on port 0.
    drive(0, 1'b1, 1'b0, 13'h010, DA5);
    step(2'b01, 1'b1, 1'b0, 13'h010, 1'b0);
    drive(0, 1'b0, 1'b1, 13'h010, '0);
    exp_rd(0, DA5);
    step(2'b01, 1'b0, 1'b1, 13'h010, 1'b0);
    idle_ports();
    step(2'b00, 1'b0, 1'b0, 13'h000, 1'b0);

    // Test 2: preload, then both ports read every cycle.
    do_reset();
    drive(0, 1'b1, 1'b0, 13'h001, D1);
    step(2'b01, 1'b1, 1'b0, 13'h001, 1'b0);
    idle_ports();
    drive(1, 1'b1, 1'b0, 13'h002, D2);
    step(2'b10, 1'b1, 1'b0, 13'h002, 1'b0);
    idle_ports();
    drive(0, 1'b0, 1'b1, 13'h001, '0);
    drive(1, 1'b0, 1'b1, 13'h002, '0);
    for (int k = 0; k < 2; k++) begin
      exp_rd(0, D1);
      step(2'b01, 1'b0, 1'b1, 13'h001, 1'b0);
      exp_rd(1, D2);
      step(2'b10, 1'b0, 1'b1, 13'h002, 1'b0);
    end
    idle_ports();
    step(2'b00, 1'b0, 1'b0, 13'h000, 1'b0);

    // Test 3: clock enable 1,0,1 with requests pending.
    do_reset();
    drive(0, 1'b0, 1'b1, 13'h001, '0);
    exp_rd(0, D1);
    step(2'b01, 1'b0, 1'b1, 13'h001, 1'b0);
    idle_ports();
    drive(1, 1'b0, 1'b1, 13'h002, '0);
    en = 1'b0;
    step(2'b00, 1'b0, 1'b0, 13'h000, 1'b0);
    en = 1'b1;
    #2;
    chk("en_hold_vld", 160'(rd_vld), 160'(2'b01));
    chk("en_hold_data", 160'(rd_data), 160'(D1));
    exp_rd(1, D2);
    step(2'b10, 1'b0, 1'b1, 13'h002, 1'b0);
    idle_ports();
    step(2'b00, 1'b0, 1'b0, 13'h000, 1'b0);

    // Test 4a: reset pulse discards a pending port-1 read return.
    do_reset();
    drive(1, 1'b0, 1'b1, 13'h002, '0);
    step(2'b10, 1'b0, 1'b1, 13'h002, 1'b0);
    chk("pend_vld", 160'(rd_vld), 160'(2'b10));
    #1;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b1, 13'h001, '0);
    drive(1, 1'b0, 1'b1, 13'h002, '0);
    #1;
    chk("rst_pulse_vld", 160'(rd_vld), 160'(0));
    chk("rst_pulse_gnt", 160'({gnt, mem_wr, mem_rd}), 160'(0));
    #1;
    rst_n = 1'b1;
    exp_rd(0, D1);
    step(2'b01, 1'b0, 1'b1, 13'h001, 1'b0);
    idle_ports();
    step(2'b00, 1'b0, 1'b0, 13'h000, 1'b0);

    // Test 4b: reset clears a priority pointer that favours port 1.
    drive(0, 1'b1, 1'b0, 13'h007, D7);
    step(2'b01, 1'b1, 1'b0, 13'h007, 1'b0);
    rst_n = 1'b0;
    idle_ports();
    drive(0, 1'b0, 1'b1, 13'h001, '0);
    drive(1, 1'b0, 1'b1, 13'h002, '0);
    #2;
    rst_n = 1'b1;
    exp_rd(0, D1);
    step(2'b01, 1'b0, 1'b1, 13'h001, 1'b0);
    drive(0, 1'b0, 1'b0, 13'h000, '0);
    exp_rd(1, D2);
    step(2'b10, 1'b0, 1'b1, 13'h002, 1'b0);
    idle_ports();
    step(2'b00, 1'b0, 1'b0, 13'h000, 1'b0);

`ifdef RAM_ARB_LOCK_EN
    // Test 5: port 0 locks for three cycles, port 1 waits.
    do_reset();
    drive(0, 1'b0, 1'b1, 13'h001, '0);
    drive(1, 1'b0, 1'b1, 13'h002, '0);
    alock = 2'b01;
    for (int k = 0; k < 3; k++) begin
      exp_rd(0, D1);
      step(2'b01, 1'b0, 1'b1, 13'h001, 1'b0);
    end
    alock = 2'b00;
    exp_rd(1, D2);
    step(2'b10, 1'b0, 1'b1, 13'h002, 1'b0);
    idle_ports();
    step(2'b00, 1'b0, 1'b0, 13'h000, 1'b0);

    // Test 6: stuck lock is broken on the 16th locked cycle.
    do_reset();
    drive(0, 1'b0, 1'b1, 13'h001, '0);
    drive(1, 1'b0, 1'b1, 13'h002, '0);
    alock = 2'b01;
    exp_rd(0, D1);
    step(2'b01, 1'b0, 1'b1, 13'h001, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      exp_rd(0, D1);
      step(2'b01, 1'b0, 1'b1, 13'h001, (k == 16));
    end
    exp_rd(1, D2);
    step(2'b10, 1'b0, 1'b1, 13'h002, 1'b0);
    idle_ports();
    alock = 2'b00;
    step(2'b00, 1'b0, 1'b0, 13'h000, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rd_queue_drained", 160'(rq.size()), 160'(0));
    chk("gnt_queue_drained", 160'(gq.size()), 160'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
